// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-byte holding register.
// The line is synchronised, the start bit is qualified at mid-bit, and eight
// data bits plus the stop bit are sampled at the centre of each bit cell.
// The CPU polls ready and acknowledges with a one-cycle rd strobe.
// ferr and ovr are sticky until the next rd.
module uart_rx #(
  parameter int BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data,
  output logic       ready,
  output logic       ferr,
  output logic       ovr
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          rx_meta;
  logic          rx_s;
  logic [1:0]    primed;
  logic          armed;
  logic [2:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          tick;
  logic          load_evt;
  logic          ferr_evt;

  // Sample points fall where the baud counter has run down to zero.
  assign tick     = (baud_cnt == '0);
  assign load_evt = (state == S_STOP) && tick && rx_s;
  assign ferr_evt = (state == S_STOP) && tick && !rx_s;

  // Two-flop synchroniser; it resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // primed marks when rx_s reflects the real line rather than its reset value;
  // armed records that the real line has been seen high since reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      primed <= 2'b00;
      armed  <= 1'b0;
    end else begin
      primed <= {primed[0], 1'b1};
      armed  <= armed | (primed[1] & rx_s);
    end
  end

  // Frame sequencer: start qualification, data shifting and stop check.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (primed[1] && !rx_s) begin
            if (armed) begin
              state    <= S_START;
              baud_cnt <= HALF_LOAD;
            end else begin
              state <= S_BREAK;
            end
          end
        end
        S_START: begin
          if (tick) begin
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              state    <= S_DATA;
              baud_cnt <= FULL_LOAD;
              bit_cnt  <= 3'd0;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        S_DATA: begin
          if (tick) begin
            shift    <= {rx_s, shift[7:1]};
            baud_cnt <= FULL_LOAD;
            if (bit_cnt == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        S_STOP: begin
          if (tick) begin
            state <= rx_s ? S_IDLE : S_BREAK;
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Holding register and status flags; a new byte or error beats rd.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data  <= 8'h00;
      ready <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      if (load_evt) begin
        data  <= shift;
        ready <= 1'b1;
        ovr   <= rd ? 1'b0 : (ovr | ready);
        ferr  <= rd ? 1'b0 : ferr;
      end else if (ferr_evt) begin
        ferr <= 1'b1;
        if (rd) begin
          ready <= 1'b0;
          ovr   <= 1'b0;
        end
      end else if (rd) begin
        ready <= 1'b0;
        ferr  <= 1'b0;
        ovr   <= 1'b0;
      end
    end
  end

endmodule
